seg_disp_arbiter: RTL and testbench

Shares the 2-digit multiplexed 7-segment display between two byte producers, for example the UART receive path and a local status source. It runs a round-robin req/ack arbitration with a guaranteed minimum display hold per grant. It latches the granted byte and drives the digit scan directly: hex decode, bit-select and segment outputs. It sits between the producers and the board pins and replaces any free-running display driver.

---
 rtl/seg_disp_arbiter.sv | 148 ++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - round-robin two-producer arbiter driving a 2-digit multiplexed 7-segment display
// Optional feature macro SEG_DP_OWNER_EN: digit 1 decimal point lit while requester B owns the display.
module seg_disp_arbiter #(
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned SCAN_CYC = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic       busy,
  output logic [1:0] cs,
  output logic [7:0] dx
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]      disp_q, disp_d;
  logic            owner_b_q, owner_b_d;
  logic            shown_q, shown_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic            digit_q, digit_d;
  logic [1:0]      cs_q, cs_d;
  logic [7:0]      dx_q, dx_d;
  logic            grant_b;
  logic            scan_wrap;
  logic [3:0]      nibble;
  logic [7:0]      seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      disp_q     <= '0;
      owner_b_q  <= 1'b1;
      shown_q    <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      scan_cnt_q <= '0;
      digit_q    <= 1'b0;
      cs_q       <= 2'b11;
      dx_q       <= 8'hFF;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      disp_q     <= disp_d;
      owner_b_q  <= owner_b_d;
      shown_q    <= shown_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      cs_q       <= cs_d;
      dx_q       <= dx_d;
    end
  end

  // owner_b_q doubles as last_owner: on a tie the other requester wins.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    disp_d     = disp_q;
    owner_b_d  = owner_b_q;
    shown_d    = shown_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    grant_b    = req_b && (!req_a || !owner_b_q);
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          disp_d     = grant_b ? data_b : data_a;
          owner_b_d  = grant_b;
          ack_a_d    = !grant_b;
          ack_b_d    = grant_b;
          hold_cnt_d = HW'(HOLD_CYC - 1);
          shown_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_wrap  = (scan_cnt_q == SW'(SCAN_CYC - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_d    = digit_q ^ scan_wrap;
  end

  always_comb begin
    nibble = digit_q ? disp_q[7:4] : disp_q[3:0];
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
`ifdef SEG_DP_OWNER_EN
    seg[7] = ~(digit_q & owner_b_q);
`else
    seg[7] = 1'b1;
`endif
    if (!shown_q) begin
      cs_d = 2'b11;
      dx_d = 8'hFF;
    end else begin
      cs_d = digit_q ? 2'b01 : 2'b10;
      dx_d = seg;
    end
  end

  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign busy  = (state_q == HOLD);
  assign cs    = cs_q;
  assign dx    = dx_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - self-checking bench for seg_disp_arbiter with directed scenarios and a random run
module tb_seg_disp_arbiter;

  localparam int HOLD = 8;
  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic       ack_a, ack_b, busy;
  logic [1:0] cs;
  logic [7:0] dx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_disp_arbiter #(.HOLD_CYC(HOLD), .SCAN_CYC(SCAN)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .busy(busy), .cs(cs), .dx(dx)
  );

  function automatic logic [7:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // Display seen after the n-th edge since reset release, byte b latched by owner ob.
  function automatic logic [1:0] exp_cs(input int n);
    return (((n - 1) / SCAN) % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [7:0] exp_dx(input int n, input logic [7:0] b, input logic ob);
    logic [7:0] v;
    int d;
    d = ((n - 1) / SCAN) % 2;
    v = seg7(d == 1 ? b[7:4] : b[3:0]);
`ifdef SEG_DP_OWNER_EN
    if (d == 1 && ob) v[7] = 1'b0;
`endif
    return v;
  endfunction

  // Transaction-level reference: grant times, a free-at edge, and the latched byte.
  int         m_edge = 0, m_tlast = -100, m_free = 1, m_dig;
  logic [7:0] m_disp = 8'h00;
  logic       m_shown = 1'b0, m_last_b = 1'b1, m_gb;
  logic       e_ack_a = 1'b0, e_ack_b = 1'b0, e_busy = 1'b0;
  logic [1:0] e_cs = 2'b11;
  logic [7:0] e_dx = 8'hFF;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_edge = 0; m_tlast = -100; m_free = 1; m_disp = 8'h00;
        m_shown = 1'b0; m_last_b = 1'b1;
        e_ack_a = 1'b0; e_ack_b = 1'b0; e_busy = 1'b0; e_cs = 2'b11; e_dx = 8'hFF;
      end else begin
        m_edge = m_edge + 1;
        if (!m_shown) begin
          e_cs = 2'b11; e_dx = 8'hFF;
        end else begin
          e_cs = exp_cs(m_edge);
          e_dx = exp_dx(m_edge, m_disp, m_last_b);
        end
        e_ack_a = 1'b0; e_ack_b = 1'b0;
        if (m_edge >= m_free && (req_a || req_b)) begin
          m_gb = (req_a && req_b) ? !m_last_b : req_b;
          m_disp = m_gb ? data_b : data_a;
          m_last_b = m_gb;
          m_shown = 1'b1;
          m_tlast = m_edge;
          m_free = m_edge + HOLD + 1;
          e_ack_a = !m_gb; e_ack_b = m_gb;
        end
        e_busy = (m_edge - m_tlast) < HOLD;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (cs !== 2'b11) begin n_err++; $display("FAIL reset_cs got %b exp 11", cs); end
    n_vec++; if (dx !== 8'hFF) begin n_err++; $display("FAIL reset_dx got %h exp FF", dx); end
    n_vec++; if ({ack_a, ack_b, busy} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b exp 000", {ack_a, ack_b, busy}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++; if (cs !== 2'b11 || dx !== 8'hFF) begin n_err++; $display("FAIL idle_blank got cs=%b dx=%h exp 11/FF", cs, dx); end
  endtask

  task automatic test_single();
    logic [1:0] ecs;
    logic [7:0] edx;
    do_reset();
    data_a = 8'h3C; req_a = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      ecs = (n == 1) ? 2'b11 : exp_cs(n);
      edx = (n == 1) ? 8'hFF : exp_dx(n, 8'h3C, 1'b0);
      n_vec++; if (ack_a !== (n == 1)) begin n_err++; $display("FAIL single_ack_a n=%0d got %b", n, ack_a); end
      n_vec++; if (ack_b !== 1'b0) begin n_err++; $display("FAIL single_ack_b n=%0d got %b exp 0", n, ack_b); end
      n_vec++; if (busy !== (n <= HOLD)) begin n_err++; $display("FAIL single_busy n=%0d got %b", n, busy); end
      n_vec++; if (cs !== ecs || dx !== edx) begin n_err++; $display("FAIL single_disp n=%0d got %b/%h exp %b/%h", n, cs, dx, ecs, edx); end
      if (n == 1) req_a = 1'b0;
    end
  endtask

  task automatic test_tie();
    logic [1:0] ecs;
    logic [7:0] edx;
    logic       eb;
    do_reset();
    data_a = 8'hA7; data_b = 8'h5E; req_a = 1'b1; req_b = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      eb = (n <= 8) || (n >= 10 && n <= 17);
      if (n == 1) begin ecs = 2'b11; edx = 8'hFF; end
      else if (n <= 10) begin ecs = exp_cs(n); edx = exp_dx(n, 8'hA7, 1'b0); end
      else begin ecs = exp_cs(n); edx = exp_dx(n, 8'h5E, 1'b1); end
      n_vec++; if (ack_a !== (n == 1) || ack_b !== (n == 10)) begin n_err++; $display("FAIL tie_ack n=%0d got a=%b b=%b", n, ack_a, ack_b); end
      n_vec++; if (busy !== eb) begin n_err++; $display("FAIL tie_busy n=%0d got %b exp %b", n, busy, eb); end
      n_vec++; if (cs !== ecs || dx !== edx) begin n_err++; $display("FAIL tie_disp n=%0d got %b/%h exp %b/%h", n, cs, dx, ecs, edx); end
      if (n == 1) req_a = 1'b0;
      if (n == 10) req_b = 1'b0;
    end
  endtask

  task automatic test_hold_req();
    do_reset();
    data_a = 8'h12; req_a = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      n_vec++; if (ack_b !== (n == 10)) begin n_err++; $display("FAIL holdreq_ack_b n=%0d got %b", n, ack_b); end
      n_vec++; if (busy !== (n <= 8 || n >= 10)) begin n_err++; $display("FAIL holdreq_busy n=%0d got %b", n, busy); end
      if (n == 1) req_a = 1'b0;
      if (n == 3) begin data_b = 8'h4F; req_b = 1'b1; end
      if (n == 10) req_b = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int  g[4];
    logic eb;
    g = '{1, 10, 19, 28};
    do_reset();
    data_a = 8'h21; req_a = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      @(negedge clk);
      eb = 1'b0;
      for (int k = 0; k < 4; k++) if (n - g[k] >= 0 && n - g[k] < HOLD) eb = 1'b1;
      n_vec++; if (ack_a !== (n == 1 || n == 19)) begin n_err++; $display("FAIL rr_ack_a n=%0d got %b", n, ack_a); end
      n_vec++; if (ack_b !== (n == 10 || n == 28)) begin n_err++; $display("FAIL rr_ack_b n=%0d got %b", n, ack_b); end
      n_vec++; if (busy !== eb) begin n_err++; $display("FAIL rr_busy n=%0d got %b exp %b", n, busy, eb); end
      if (n == 1) req_a = 1'b0;
      if (n == 8) begin data_b = 8'h9B; req_a = 1'b1; req_b = 1'b1; end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    logic [1:0] ecs;
    logic [7:0] edx;
    do_reset();
    data_a = 8'h77; req_a = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      n_vec++; if (ack_a !== (n == 1) || busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre n=%0d got ack=%b busy=%b", n, ack_a, busy); end
      if (n == 1) req_a = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0 || cs !== 2'b11 || dx !== 8'hFF || ack_a !== 1'b0)
      begin n_err++; $display("FAIL midrst_async got busy=%b cs=%b dx=%h ack=%b exp 0/11/FF/0", busy, cs, dx, ack_a); end
    #2;
    rst = 1'b0;
    data_a = 8'h3C; req_a = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      ecs = (n == 1) ? 2'b11 : exp_cs(n);
      edx = (n == 1) ? 8'hFF : exp_dx(n, 8'h3C, 1'b0);
      n_vec++; if (ack_a !== (n == 1) || busy !== 1'b1) begin n_err++; $display("FAIL midrst_regrant n=%0d got ack=%b busy=%b", n, ack_a, busy); end
      n_vec++; if (cs !== ecs || dx !== edx) begin n_err++; $display("FAIL midrst_disp n=%0d got %b/%h exp %b/%h", n, cs, dx, ecs, edx); end
      if (n == 1) req_a = 1'b0;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_vec++; if (ack_a !== e_ack_a || ack_b !== e_ack_b) begin n_err++; $display("FAIL rand_ack i=%0d got %b%b exp %b%b", i, ack_a, ack_b, e_ack_a, e_ack_b); end
      n_vec++; if (busy !== e_busy) begin n_err++; $display("FAIL rand_busy i=%0d got %b exp %b", i, busy, e_busy); end
      n_vec++; if (cs !== e_cs || dx !== e_dx) begin n_err++; $display("FAIL rand_disp i=%0d got %b/%h exp %b/%h", i, cs, dx, e_cs, e_dx); end
      n_vec++; if (cs === 2'b00) begin n_err++; $display("FAIL rand_overlap i=%0d got cs=00 exp one-hot-low", i); end
      if (ack_a) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 3) == 0) begin data_a = 8'($urandom); req_a = 1'b1; end
      if (ack_b) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 3) == 0) begin data_b = 8'($urandom); req_b = 1'b1; end
      if (i == 400) begin rst = 1'b1; #2; rst = 1'b0; end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_hold_req();
    test_round_robin();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
